// File: rtl/chebyshev_openmp_mul_arb_pkg.sv
// Shared widths and latency for the round-robin multiply/accumulate arbiter.
package chebyshev_openmp_mul_arb_pkg;

    localparam int unsigned OPND_W   = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned PIPE_LAT = 2;

endpackage

// File: rtl/chebyshev_openmp_mul_mul_16s_16s_32_1_1.sv
// Single-stage (combinational) signed 16x16 -> 32 multiplier.
module chebyshev_openmp_mul_mul_16s_16s_32_1_1 #(
    parameter int unsigned NUM_STAGE  = 1,
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 16,
    parameter int unsigned DOUT_WIDTH = 32
) (
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic [DOUT_WIDTH-1:0] dout
);

    if (NUM_STAGE == 1) begin : g_comb
        assign dout = $signed(din0) * $signed(din1);
    end else begin : g_unsupported
        assign dout = '0;
    end

endmodule

// File: rtl/chebyshev_openmp_mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters,
// with a two-stage pipeline feeding per-requester 32-bit accumulators.
module chebyshev_openmp_mul_arb
    import chebyshev_openmp_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic [NUM_REQ-1:0]          req_vld,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic [OPND_W*NUM_REQ-1:0]   req_din0,
    input  logic [OPND_W*NUM_REQ-1:0]   req_din1,
    input  logic [NUM_REQ-1:0]          req_acc,
    output logic                        res_vld,
    output logic [ID_W-1:0]             res_id,
    output logic [PROD_W-1:0]           res_dout
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic              gnt_acc;
    logic [OPND_W-1:0] mul_a;
    logic [OPND_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;

    logic              s1_vld;
    logic              s1_acc;
    logic [ID_W-1:0]   s1_id;
    logic [PROD_W-1:0] s1_prod;

    logic [PROD_W-1:0] acc_q [NUM_REQ];
    logic [PROD_W-1:0] acc_nxt;

    // Search starts at ptr and wraps; the first asserted valid wins.
    always_comb begin
        req_rdy = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (!ap_rst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((ptr + k) % NUM_REQ);
                if (!gnt_any && req_vld[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
        if (gnt_any) begin
            req_rdy[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        gnt_acc = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                mul_a   = req_din0[i*OPND_W +: OPND_W];
                mul_b   = req_din1[i*OPND_W +: OPND_W];
                gnt_acc = req_acc[i];
            end
        end
    end

    assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    chebyshev_openmp_mul_mul_16s_16s_32_1_1 #(
        .NUM_STAGE  (1),
        .DIN0_WIDTH (OPND_W),
        .DIN1_WIDTH (OPND_W),
        .DOUT_WIDTH (PROD_W)
    ) u_mul (
        .din0 (mul_a),
        .din1 (mul_b),
        .dout (prod)
    );

    // Stage 2 writes acc_q on the same edge it registers the result, so a
    // back-to-back accumulate to the same id already reads the fresh value.
    assign acc_nxt = (s1_acc ? acc_q[s1_id] : '0) + s1_prod;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr      <= '0;
            s1_vld   <= 1'b0;
            s1_acc   <= 1'b0;
            s1_id    <= '0;
            s1_prod  <= '0;
            res_vld  <= 1'b0;
            res_id   <= '0;
            res_dout <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
            s1_vld  <= gnt_any;
            s1_acc  <= gnt_acc;
            s1_id   <= gnt_id;
            s1_prod <= prod;
            res_vld <= s1_vld;
            if (s1_vld) begin
                acc_q[s1_id] <= acc_nxt;
                res_id       <= s1_id;
                res_dout     <= acc_nxt;
            end
        end
    end

endmodule

// File: doc/chebyshev_openmp_mul_arb.md
CHEBYSHEV_OPENMP_MUL_ARB -- requirements
Module: chebyshev_openmp_mul_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 Parameter ID_W, default 2, width of requester index; SHALL equal clog2(NUM_REQ), minimum 1.
REQ-003 ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 ap_rst  in  1  reset, synchronous, active-high.
REQ-005 req_vld  in  NUM_REQ  per-requester operand valid.
REQ-006 req_rdy  out  NUM_REQ  per-requester operand accepted this cycle.
REQ-007 req_din0  in  16*NUM_REQ  signed operand A; slice i belongs to requester i.
REQ-008 req_din1  in  16*NUM_REQ  signed operand B; slice i belongs to requester i.
REQ-009 req_acc  in  NUM_REQ  1 = add product to requester accumulator; 0 = load product.
REQ-010 res_vld  out  1  result valid, one-cycle pulse per accepted request.
REQ-011 res_id  out  ID_W  index of requester owning the result.
REQ-012 res_dout  out  32  signed result: product, or accumulator value after add.

Function
REQ-013 At most one request SHALL be granted per cycle; req_rdy SHALL be one-hot or all-zero.
REQ-014 req_rdy[i] SHALL be combinational from req_vld and the round-robin pointer; handshake completes when req_vld[i] and req_rdy[i] are both 1.
REQ-015 Arbitration SHALL be round-robin: search starts at index ptr, wraps NUM_REQ-1 -> 0, first asserted req_vld wins.
REQ-016 On a grant to i, ptr SHALL become (i+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-017 Granted operands SHALL drive a single 16s x 16s -> 32 signed combinational multiplier; product width 32, no truncation.
REQ-018 Stage 1 (grant cycle): product, req_acc bit, and grant index SHALL be registered.
REQ-019 Stage 2: if acc bit = 0, acc[id] <= product; if 1, acc[id] <= acc[id] + product, modulo 2^32 (wrap, no saturation).
REQ-020 res_vld/res_id/res_dout SHALL be registered outputs of stage 2; latency from handshake to res_vld = 2 cycles.
REQ-021 res_dout SHALL equal the new accumulator value written in the same stage.
REQ-022 Throughput: one request per cycle sustained; back-to-back grants to the same requester with acc=1 SHALL use the in-flight stage-2 value (bypass), never a stale accumulator.
REQ-023 No backpressure on result side; consumer SHALL sample res_vld every cycle.
REQ-024 Requester holding req_vld without grant SHALL keep operands stable; block SHALL NOT depend on that for correctness of other requesters.
REQ-025 All requesters idle: req_rdy = 0, pipeline drains, res_vld = 0 after last result.
REQ-026 Worst-case wait for a continuously asserted request SHALL be NUM_REQ-1 cycles.

Reset
REQ-027 While ap_rst = 1: req_rdy = 0, ptr = 0, stage-1/stage-2 valids = 0, res_vld = 0, res_id = 0, res_dout = 0, all accumulators = 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight products; no res_vld in the cycle after ap_rst deasserts.
REQ-029 First grant after reset SHALL follow REQ-015 with ptr = 0.

Structure
REQ-030 Shared package SHALL hold operand width 16, product width 32, and the pipeline latency constant 2.
REQ-031 Multiplier SHALL be one sub-module instance, chebyshev_openmp_mul_mul_16s_16s_32_1_1 (NUM_STAGE 1, din0/din1 16, dout 32); no other multiplier in the block.
REQ-032 Arbiter, pipeline registers, and accumulator array SHALL reside in this module; accumulator array SHALL be registers, not RAM.

Verification
REQ-033 Single requester: req0 A=3,B=-4,acc=0 -> 2 cycles later res_vld=1,res_id=0,res_dout=-12.
REQ-034 Accumulate: req1 (7,6,acc=0) then (2,5,acc=1) back-to-back -> results 42 then 52, id=1, consecutive cycles.
REQ-035 Fairness: all four req_vld held high from reset -> grant order 0,1,2,3,0,... one per cycle, res_id follows same order.
REQ-036 Extremes: A=-32768,B=-32768,acc=0 -> res_dout=0x40000000; then acc=1 with same operands twice more -> 0x80000000, then 0xC0000000 (wrap).
REQ-037 Reset mid-flight: grant req2 (100,100), assert ap_rst next cycle -> no res_vld; after release, req2 (1,1,acc=1) -> res_dout=1.
REQ-038 Sparse: req_vld only on 3 then 1 with ptr=2 -> grant 3 first, then 1; idle cycles yield req_rdy=0, res_vld=0.
